speck_hash_padder: RTL



---
 rtl/speck_hash_padder.sv | 129 ++++++++++++
 1 files changed

// File: rtl/speck_hash_padder.sv
// Byte-stream to 64-bit word formatter for the SPECK hash core.
// Appends 0x80, zero fill to a word boundary and a 64-bit big-endian bit-length word.
module speck_hash_padder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    input  logic        din_last,
    output logic        din_ready,
    output logic [63:0] X,
    output logic        x_valid,
    input  logic        x_ready,
    output logic        x_last,
    output logic        msg_done
);

    typedef enum logic [1:0] {S_FILL, S_PAD, S_LEN, S_LAST} state_t;

    state_t      r_state, w_state_nx;
    logic [63:0] r_asm,   w_asm_nx;
    logic [3:0]  r_cnt,   w_cnt_nx;
    logic [63:0] r_len,   w_len_nx;
    logic [63:0] r_x,     w_x_nx;
    logic        r_xv,    w_xv_nx;
    logic        r_xl,    w_xl_nx;
    logic        r_done;

    logic        w_accept;
    logic        w_xfer;
    logic [5:0]  w_sh;
    logic [63:0] w_byte_sh;
    logic [63:0] w_pad_sh;
    logic [63:0] w_bits;

    assign din_ready = (r_state == S_FILL) && (r_cnt < 4'd8);
    assign w_accept  = din_valid && din_ready;
    assign w_xfer    = (r_cnt == 4'd8) && (!r_xv || x_ready);

    // Byte position cnt maps to bits [63-8*cnt -: 8]; lanes above cnt are already zero.
    assign w_sh      = {r_cnt[2:0], 3'b000};
    assign w_byte_sh = {din, 56'd0} >> w_sh;
    assign w_pad_sh  = {8'h80, 56'd0} >> w_sh;
    assign w_bits    = r_len << 3;

    always_comb begin
        w_state_nx = r_state;
        w_asm_nx   = r_asm;
        w_cnt_nx   = r_cnt;
        w_len_nx   = r_len;
        w_x_nx     = r_x;
        w_xv_nx    = r_xv;
        w_xl_nx    = r_xl;

        if (w_xfer) begin
            w_x_nx   = r_asm;
            w_xv_nx  = 1'b1;
            w_xl_nx  = (r_state == S_LAST);
            w_cnt_nx = '0;
            w_asm_nx = '0;
        end else if (r_xv && x_ready) begin
            w_xv_nx = 1'b0;
            w_xl_nx = 1'b0;
        end

        // Byte writes need cnt<8 and transfers need cnt==8, so the two never collide.
        case (r_state)
            S_FILL: begin
                if (w_accept) begin
                    w_asm_nx = r_asm | w_byte_sh;
                    w_cnt_nx = r_cnt + 4'd1;
                    w_len_nx = r_len + 64'd1;
                    if (din_last) w_state_nx = S_PAD;
                end
            end
            S_PAD: begin
                if (r_cnt != 4'd8) begin
                    w_asm_nx   = r_asm | w_pad_sh;
                    w_cnt_nx   = 4'd8;
                    w_state_nx = S_LEN;
                end
            end
            S_LEN: begin
                if (r_cnt == 4'd0) begin
                    w_asm_nx   = w_bits;
                    w_cnt_nx   = 4'd8;
                    w_state_nx = S_LAST;
                end
            end
            S_LAST: begin
                if (w_xfer) begin
                    w_len_nx   = '0;
                    w_state_nx = S_FILL;
                end
            end
            default: w_state_nx = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_FILL;
        else          r_state <= w_state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_asm  <= '0;
            r_cnt  <= '0;
            r_len  <= '0;
            r_x    <= '0;
            r_xv   <= 1'b0;
            r_xl   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_asm  <= w_asm_nx;
            r_cnt  <= w_cnt_nx;
            r_len  <= w_len_nx;
            r_x    <= w_x_nx;
            r_xv   <= w_xv_nx;
            r_xl   <= w_xl_nx;
            r_done <= r_xv && r_xl && x_ready;
        end
    end

    assign X        = r_x;
    assign x_valid  = r_xv;
    assign x_last   = r_xl;
    assign msg_done = r_done;

endmodule
